// File: rtl/sll_multicycle.sv
// Iterative 32-bit logical left shifter: one binary-weighted stage per clock
// (16 on accept, then 8/4/2/1), with a sticky flag for bits lost off bit 31.
module sll_multicycle (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_start,
    input  logic [31:0] data_operandA,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        data_resultRDY,
    output logic        data_overflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] w_q;
    logic [4:0]  a_q;
    logic [2:0]  k_q;
    logic        o_q;
    logic        rdy_q;
    logic        busy_q;

    logic [31:0] load_w_d;
    logic        load_o_d;
    logic [31:0] stage_w_d;
    logic        stage_o_d;

    // The 16-bit stage is folded into the accepting edge.
    assign load_w_d = ctrl_shiftamt[4] ? {data_operandA[15:0], 16'h0000} : data_operandA;
    assign load_o_d = ctrl_shiftamt[4] & (|data_operandA[31:16]);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        stage_w_d = w_q;
        stage_o_d = o_q;
        case (k_q)
            3'd0: if (a_q[3]) begin
                stage_w_d = {w_q[23:0], 8'h00};
                stage_o_d = o_q | (|w_q[31:24]);
            end
            3'd1: if (a_q[2]) begin
                stage_w_d = {w_q[27:0], 4'h0};
                stage_o_d = o_q | (|w_q[31:28]);
            end
            3'd2: if (a_q[1]) begin
                stage_w_d = {w_q[29:0], 2'b00};
                stage_o_d = o_q | (|w_q[31:30]);
            end
            default: if (a_q[0]) begin
                stage_w_d = {w_q[30:0], 1'b0};
                stage_o_d = o_q | w_q[31];
            end
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            a_q     <= '0;
            k_q     <= '0;
            o_q     <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    rdy_q <= 1'b0;
                    if (ctrl_start) begin
                        w_q     <= load_w_d;
                        o_q     <= load_o_d;
                        a_q     <= ctrl_shiftamt;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    w_q <= stage_w_d;
                    o_q <= stage_o_d;
                    k_q <= k_q + 3'd1;
                    if (k_q == 3'd3) begin
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_result    = w_q;
    assign data_overflow  = o_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
